// File: rtl/msg_arbiter_rr_pkg.sv
// msg_arbiter_rr_pkg: shared defaults, state encoding and frame layout for msg_arbiter_rr.
// Holds the default channel count and sync byte, the FSM state type and the
// byte offsets of the frame fields. CSUM exists only with MSG_ARBITER_CSUM_EN.
package msg_arbiter_rr_pkg;
    localparam int N_SRC_DEF = 25;
    localparam logic [7:0] START_BYTE_DEF = 8'h5A;
    localparam int OFF_START = 0;
    localparam int OFF_ADDR = 1;
    localparam int OFF_LEN = 2;
    localparam int OFF_PAYLOAD = 3;
    typedef enum logic [2:0] {
        IDLE,
        START,
        ADDR,
        LEN,
        PAYLOAD,
`ifdef MSG_ARBITER_CSUM_EN
        CSUM,
`endif
        DRAIN,
        GAP
    } state_e;
    function automatic logic [7:0] addr_byte(input int base, input int g);
        return 8'(base + g);
    endfunction
endpackage

// File: rtl/msg_arbiter_rr_picker.sv
// rr_picker: combinational round-robin search starting just above a pointer.
// Ports: req_i request vector, ptr_i last granted index,
//        found_o any request present, idx_o first requester after ptr_i (wrapping).
module rr_picker #(
    parameter int N = 25,
    parameter int PW = 5
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic          found_o,
    output logic [PW-1:0] idx_o
);
    logic [N-1:0] rot;
    int start;
    int hit;
    // Rotating a doubled copy puts ptr+1 at bit 0, so a plain lowest-bit
    // priority encode yields the wrap-around search order.
    always_comb begin
        start = (int'(ptr_i) + 1) % N;
        rot = N'({req_i, req_i} >> start);
        found_o = 1'b0;
        hit = 0;
        for (int k = N - 1; k >= 0; k--) begin
            if (rot[k]) begin
                found_o = 1'b1;
                hit = k;
            end
        end
        idx_o = PW'((start + hit) % N);
    end
endmodule

// File: rtl/msg_arbiter_rr.sv
// msg_arbiter_rr: round-robin reply collector framing START/ADDR/LEN/payload onto a byte stream.
// Ports: clk, n_rst (async active-low); have_msg_bus/len_bus/data_bus from N_SRC
//        show-ahead channels, rdreq_bus one-cycle pop strobes back to them;
//        tx_data/tx_valid/tx_ready byte stream to the uart; busy spans grant to last byte accepted.
// Option: define MSG_ARBITER_CSUM_EN to append an XOR checksum of ADDR, LEN and payload.
module msg_arbiter_rr
    import msg_arbiter_rr_pkg::*;
#(
    parameter int N_SRC = N_SRC_DEF,
    parameter int ADDR_BASE = 0,
    parameter logic [7:0] START_BYTE = START_BYTE_DEF,
    parameter int GAP_CYCLES = 0
) (
    input  logic               clk,
    input  logic               n_rst,
    input  logic [N_SRC-1:0]   have_msg_bus,
    input  logic [8*N_SRC-1:0] len_bus,
    input  logic [8*N_SRC-1:0] data_bus,
    output logic [N_SRC-1:0]   rdreq_bus,
    output logic [7:0]         tx_data,
    output logic               tx_valid,
    input  logic               tx_ready,
    output logic               busy
);
    localparam int PW = (N_SRC > 1) ? $clog2(N_SRC) : 1;
`ifdef MSG_ARBITER_CSUM_EN
    localparam state_e AFTER_PL = CSUM;
`else
    localparam state_e AFTER_PL = DRAIN;
`endif
    state_e state_q;
    logic [PW-1:0] ptr_q, g_q, pick_d;
    logic [7:0] cnt_q, gap_q, tx_data_q, head_d;
    logic tx_valid_q, busy_q, slot_free_d, found_d, pop_d;
`ifdef MSG_ARBITER_CSUM_EN
    logic [7:0] csum_q;
`endif
    rr_picker #(.N(N_SRC), .PW(PW)) u_pick (
        .req_i(have_msg_bus),
        .ptr_i(ptr_q),
        .found_o(found_d),
        .idx_o(pick_d)
    );
    assign slot_free_d = !tx_valid_q || tx_ready;
    assign head_d = data_bus[int'(g_q) * 8 +: 8];
    // The pop is combinational so the channel advances its head on the same
    // edge that captures the current head byte into the output slot.
    assign pop_d = (state_q == PAYLOAD) && slot_free_d && (cnt_q != 8'd0);
    assign tx_data = tx_data_q;
    assign tx_valid = tx_valid_q;
    assign busy = busy_q;
    always_comb begin
        rdreq_bus = '0;
        rdreq_bus[g_q] = pop_d;
    end
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= IDLE;
            ptr_q <= PW'(N_SRC - 1);
            g_q <= '0;
            cnt_q <= '0;
            gap_q <= '0;
            tx_data_q <= '0;
            tx_valid_q <= 1'b0;
            busy_q <= 1'b0;
`ifdef MSG_ARBITER_CSUM_EN
            csum_q <= '0;
`endif
        end else begin
            if (tx_ready) tx_valid_q <= 1'b0;
            case (state_q)
                IDLE: if (found_d) begin
                    g_q <= pick_d;
                    ptr_q <= pick_d;
                    cnt_q <= len_bus[int'(pick_d) * 8 +: 8];
                    busy_q <= 1'b1;
                    state_q <= START;
                end
                START: if (slot_free_d) begin
                    tx_valid_q <= 1'b1;
                    tx_data_q <= START_BYTE;
                    state_q <= ADDR;
                end
                ADDR: if (slot_free_d) begin
                    tx_valid_q <= 1'b1;
                    tx_data_q <= addr_byte(ADDR_BASE, int'(g_q));
`ifdef MSG_ARBITER_CSUM_EN
                    csum_q <= addr_byte(ADDR_BASE, int'(g_q));
`endif
                    state_q <= LEN;
                end
                LEN: if (slot_free_d) begin
                    tx_valid_q <= 1'b1;
                    tx_data_q <= cnt_q;
`ifdef MSG_ARBITER_CSUM_EN
                    csum_q <= csum_q ^ cnt_q;
`endif
                    state_q <= (cnt_q == 8'd0) ? AFTER_PL : PAYLOAD;
                end
                // Leaving on the last load avoids a bubble between payload and trailer.
                PAYLOAD: if (pop_d) begin
                    tx_valid_q <= 1'b1;
                    tx_data_q <= head_d;
                    cnt_q <= cnt_q - 8'd1;
`ifdef MSG_ARBITER_CSUM_EN
                    csum_q <= csum_q ^ head_d;
`endif
                    if (cnt_q == 8'd1) state_q <= AFTER_PL;
                end
`ifdef MSG_ARBITER_CSUM_EN
                CSUM: if (slot_free_d) begin
                    tx_valid_q <= 1'b1;
                    tx_data_q <= csum_q;
                    state_q <= DRAIN;
                end
`endif
                DRAIN: if (slot_free_d) begin
                    busy_q <= 1'b0;
                    gap_q <= 8'(GAP_CYCLES);
                    state_q <= (GAP_CYCLES > 0) ? GAP : IDLE;
                end
                GAP: begin
                    gap_q <= gap_q - 8'd1;
                    if (gap_q <= 8'd1) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_msg_arbiter_rr.sv
// tb_msg_arbiter_rr: scoreboard bench with a frame-level round-robin model and channel sources.
`timescale 1ns/1ps
module tb_msg_arbiter_rr;
    import msg_arbiter_rr_pkg::*;
    localparam int N = 25;
    localparam int AB = 0;
    localparam logic [7:0] SB = 8'h5A;
    localparam int K_CS = 4;
`ifdef MSG_ARBITER_CSUM_EN
    localparam int CS = 1;
`else
    localparam int CS = 0;
`endif
    logic clk = 1'b0, n_rst = 1'b0, tx_ready = 1'b0;
    logic [N-1:0] have_msg_bus = '0;
    logic [N-1:0] rdreq_bus;
    logic [8*N-1:0] len_bus = '0, data_bus = '0;
    logic [7:0] tx_data;
    logic tx_valid, busy;

    msg_arbiter_rr #(.N_SRC(N), .ADDR_BASE(AB), .START_BYTE(SB), .GAP_CYCLES(0)) dut (
        .clk(clk), .n_rst(n_rst), .have_msg_bus(have_msg_bus), .len_bus(len_bus),
        .data_bus(data_bus), .rdreq_bus(rdreq_bus), .tx_data(tx_data),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy)
    );
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] d;
        int kind;
        int ch;
        int len;
        bit last;
    } exp_t;
    exp_t exp_q[$];
    int errors = 0, checks = 0;
    int pops_seen[N], rets_seen[N], pops_done[N], rets_done[N];
    logic [7:0] bytes_q[N][$];
    logic [7:0] mdl_bytes[N][$];
    int pend_len[N][$];
    int mdl_len[N][$];
    int mptr = N - 1, ready_mode = 0, cyc = 0, t_first = 0, t_last = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: samples 3ns before each rising edge, so a handshake seen here completes at that edge.
    initial begin : monitor
        int cur_ch, fpops, p;
        bit stall, bchk;
        logic [7:0] sdata;
        exp_t e;
        cur_ch = -1; fpops = 0; stall = 0; bchk = 0; sdata = '0;
        forever begin
            @(negedge clk); #2;
            cyc++;
            if (!n_rst) begin
                cur_ch = -1; stall = 0; bchk = 0;
            end else begin
                if (stall) chk("hold_while_stalled", {tx_valid, tx_data}, {1'b1, sdata});
                if (bchk) chk("busy_low_after_frame", busy, 0);
                bchk = 0;
                if (rdreq_bus != '0) begin
                    p = -1;
                    for (int i = 0; i < N; i++) if (rdreq_bus[i]) p = i;
                    chk("rdreq_onehot", $countones(rdreq_bus), 1);
                    chk("rdreq_channel", p, cur_ch);
                    if (p >= 0) pops_seen[p]++;
                    fpops++;
                end
                if (tx_valid && tx_ready) begin
                    if (exp_q.size() == 0) chk("tx_without_expect", exp_q.size(), 1);
                    else begin
                        e = exp_q.pop_front();
                        chk($sformatf("tx_byte_k%0d_ch%0d", e.kind, e.ch), tx_data, e.d);
                        chk("busy_in_frame", busy, 1);
                        if (e.kind == OFF_START) t_first = cyc;
                        if (e.kind == OFF_ADDR) begin
                            cur_ch = e.ch; fpops = 0; rets_seen[e.ch]++;
                        end
                        if (e.last) begin
                            chk($sformatf("pop_count_ch%0d", e.ch), fpops, e.len);
                            cur_ch = -1; bchk = 1; t_last = cyc;
                        end
                    end
                end
                stall = tx_valid && !tx_ready;
                sdata = tx_data;
            end
        end
    end

    task automatic drive();
        for (int c = 0; c < N; c++) begin
            have_msg_bus[c] = pend_len[c].size() != 0;
            len_bus[8*c +: 8] = (pend_len[c].size() != 0) ? 8'(pend_len[c][0]) : 8'h00;
            data_bus[8*c +: 8] = (bytes_q[c].size() != 0) ? bytes_q[c][0] : 8'h00;
        end
    endtask

    // Applies the pops and grants the monitor observed at the edge just passed.
    task automatic tick();
        @(posedge clk); #1;
        for (int c = 0; c < N; c++) begin
            while (pops_done[c] < pops_seen[c]) begin
                if (bytes_q[c].size() != 0) bytes_q[c].delete(0);
                pops_done[c]++;
            end
            while (rets_done[c] < rets_seen[c]) begin
                if (pend_len[c].size() != 0) pend_len[c].delete(0);
                rets_done[c]++;
            end
        end
        tx_ready = (ready_mode == 0) ? 1'b1 :
                   (ready_mode == 1) ? ($urandom_range(0, 9) < 7) :
                   ((cyc % 4 == 0) || (cyc % 4 == 3));
        drive();
    endtask

    task automatic add_msg(input int c, input int len, input bit rnd, input logic [23:0] fixed);
        logic [7:0] b;
        pend_len[c].push_back(len);
        mdl_len[c].push_back(len);
        for (int i = 0; i < len; i++) begin
            b = (rnd || i > 2) ? 8'($urandom) : fixed[8*i +: 8];
            bytes_q[c].push_back(b);
            mdl_bytes[c].push_back(b);
        end
    endtask

    function automatic void push(input logic [7:0] d, input int k, input int g, input int l);
        exp_t e;
        e = '{d, k, g, l, 1'b0};
        exp_q.push_back(e);
    endfunction

    // Reference: serve pending channels in circular order after the last grant, one frame each.
    task automatic model();
        int cnt[N];
        int g, l;
        logic [7:0] a, b, x;
        for (int c = 0; c < N; c++) cnt[c] = mdl_len[c].size();
        while (1) begin
            g = -1;
            for (int k = 1; k <= N; k++) if (g < 0 && cnt[(mptr + k) % N] > 0) g = (mptr + k) % N;
            if (g < 0) break;
            mptr = g;
            cnt[g]--;
            l = mdl_len[g].pop_front();
            a = 8'(AB + g);
            push(SB, OFF_START, g, l);
            push(a, OFF_ADDR, g, l);
            push(8'(l), OFF_LEN, g, l);
            x = a ^ 8'(l);
            for (int i = 0; i < l; i++) begin
                b = mdl_bytes[g].pop_front();
                push(b, OFF_PAYLOAD, g, l);
                x ^= b;
            end
            if (CS != 0) push(x, K_CS, g, l);
            exp_q[exp_q.size() - 1].last = 1'b1;
        end
    endtask

    task automatic run_phase(input string name);
        int to;
        model();
        drive();
        to = 0;
        while (exp_q.size() != 0 && to < 3000) begin
            tick();
            to++;
        end
        repeat (3) tick();
        chk({name, "_drained"}, exp_q.size(), 0);
        chk({name, "_idle"}, {busy, tx_valid}, 2'b00);
    endtask

    task automatic flush();
        exp_q.delete();
        for (int c = 0; c < N; c++) begin
            pend_len[c].delete(); bytes_q[c].delete();
            mdl_len[c].delete(); mdl_bytes[c].delete();
            pops_done[c] = pops_seen[c];
            rets_done[c] = rets_seen[c];
        end
        mptr = N - 1;
        drive();
    endtask

    initial begin : stim
        int to, base, n;
        drive();
        #12;
        chk("rst_tx_valid", tx_valid, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rdreq", rdreq_bus, 0);
        @(posedge clk); #1;
        n_rst = 1'b1;
        for (int r = 0; r < 2; r++) begin
            add_msg(0, 1, 1, 0); add_msg(1, 1, 1, 0); add_msg(24, 1, 1, 0);
        end
        run_phase("round_robin");
        add_msg(3, 2, 0, 24'h002211);
        run_phase("single_ch3");
        chk("ch3_back_to_back", t_last - t_first, 4 + CS);
        add_msg(7, 0, 0, 0);
        run_phase("len0_ch7");
        add_msg(2, 3, 0, 24'h040201);
        run_phase("csum_ch2");
        ready_mode = 2;
        add_msg(9, 6, 1, 0); add_msg(12, 3, 1, 0);
        run_phase("backpressure_1001");
        ready_mode = 1;
        for (int ph = 0; ph < 6; ph++) begin
            n = $urandom_range(1, 5);
            for (int j = 0; j < n; j++) add_msg($urandom_range(0, N - 1), $urandom_range(0, 6), 1, 0);
            run_phase($sformatf("random%0d", ph));
        end
        ready_mode = 0;
        add_msg(5, 4, 1, 0);
        base = pops_seen[5];
        model();
        drive();
        to = 0;
        while (pops_seen[5] - base < 2 && to < 100) begin
            tick();
            to++;
        end
        chk("reach_second_pop", pops_seen[5] - base, 2);
        chk("mid_frame_valid", tx_valid, 1);
        #1 n_rst = 1'b0;
        #1;
        chk("async_rst_tx_valid", tx_valid, 0);
        chk("async_rst_tx_data", tx_data, 0);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_rdreq", rdreq_bus, 0);
        flush();
        tick();
        tick();
        n_rst = 1'b1;
        add_msg(20, 2, 1, 0); add_msg(10, 1, 1, 0);
        run_phase("after_reset");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
